// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: synchronises the phase pins, decodes Gray-code
// transitions into step/dir pulses and keeps a wrapping position count.
module quad_step_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int END_COUNT   = 16,
    parameter int N           = (END_COUNT > 2) ? $clog2(END_COUNT) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         a_in,
    input  logic         b_in,
    input  logic         clr_err,
    output logic         step,
    output logic         dir,
    output logic [N-1:0] position,
    output logic         wrap,
    output logic         err
);

    localparam logic [N-1:0] LAST = N'(END_COUNT - 1);

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic [1:0]             s;
    logic [1:0]             prev;
    logic [2:0]             fill;
    logic                   primed;
    logic                   fwd;
    logic                   rev;
    logic                   bad;

    assign s = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        bad = &(prev ^ s);
        case ({prev, s})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: rev = 1'b1;
            default: ;
        endcase
    end

    // Decoding waits until the synchroniser holds only post-reset pin samples,
    // so whatever level the pins sit at after reset never looks like motion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_sync   <= '0;
            b_sync   <= '0;
            prev     <= 2'b00;
            fill     <= 3'd0;
            primed   <= 1'b0;
            step     <= 1'b0;
            dir      <= 1'b1;
            position <= '0;
            wrap     <= 1'b0;
            err      <= 1'b0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], a_in};
            b_sync <= {b_sync[SYNC_STAGES-2:0], b_in};
            prev   <= s;
            step   <= 1'b0;
            wrap   <= 1'b0;

            if (!primed) begin
                if (fill == 3'(SYNC_STAGES))
                    primed <= 1'b1;
                else
                    fill <= fill + 3'd1;
            end

            if (clr_err)
                err <= 1'b0;

            if (primed && enable) begin
                if (fwd) begin
                    step <= 1'b1;
                    dir  <= 1'b1;
                    if (position == LAST) begin
                        position <= '0;
                        wrap     <= 1'b1;
                    end else begin
                        position <= position + N'(1);
                    end
                end else if (rev) begin
                    step <= 1'b1;
                    dir  <= 1'b0;
                    if (position == '0) begin
                        position <= LAST;
                        wrap     <= 1'b1;
                    end else begin
                        position <= position - N'(1);
                    end
                end else if (bad) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Self-checking bench for quad_step_decoder: directed scenarios plus a random
// walk compared against a Gray-index reference model.
module tb_quad_step_decoder;

    localparam int SYNC_STAGES = 2;
    localparam int END_COUNT   = 16;
    localparam int N           = $clog2(END_COUNT);

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic         a_in = 1'b0;
    logic         b_in = 1'b0;
    logic         clr_err = 1'b0;
    logic         step;
    logic         dir;
    logic [N-1:0] position;
    logic         wrap;
    logic         err;

    int errors = 0;
    int checks = 0;

    int pipe[$];
    int m_prev = -1;
    bit m_step, m_dir, m_wrap, m_err;
    int m_pos;

    int cur = 0;
    int obs_steps, obs_wraps, obs_first, obs_cyc;
    int gray[4] = '{0, 1, 3, 2};

    quad_step_decoder #(
        .SYNC_STAGES(SYNC_STAGES),
        .END_COUNT  (END_COUNT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .a_in    (a_in),
        .b_in    (b_in),
        .clr_err (clr_err),
        .step    (step),
        .dir     (dir),
        .position(position),
        .wrap    (wrap),
        .err     (err)
    );

    always #5 clk = ~clk;

    function automatic int gidx(int v);
        case (v)
            0: return 0;
            1: return 1;
            3: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [N+3:0] dut_vec();
        return {step, dir, wrap, err, position};
    endfunction

    function automatic logic [N+3:0] exp_vec();
        return {m_step, m_dir, m_wrap, m_err, N'(m_pos)};
    endfunction

    // Reference: pins travel a SYNC_STAGES-deep delay line (-1 = pre-reset
    // filler); motion is the Gray-index distance between successive samples.
    task automatic model_edge();
        int s, d;
        if (!reset) begin
            pipe.delete();
            repeat (SYNC_STAGES) pipe.push_back(-1);
            m_prev = -1;
            m_step = 0; m_dir = 1; m_pos = 0; m_wrap = 0; m_err = 0;
            return;
        end
        s = pipe[SYNC_STAGES-1];
        m_step = 0;
        m_wrap = 0;
        if (clr_err) m_err = 0;
        if (enable && m_prev >= 0 && s >= 0) begin
            d = (gidx(s) - gidx(m_prev) + 4) % 4;
            if (d == 1) begin
                m_step = 1; m_dir = 1;
                m_wrap = (m_pos == END_COUNT - 1);
                m_pos  = (m_pos + 1) % END_COUNT;
            end else if (d == 3) begin
                m_step = 1; m_dir = 0;
                m_wrap = (m_pos == 0);
                m_pos  = (m_pos + END_COUNT - 1) % END_COUNT;
            end else if (d == 2) begin
                m_err = 1;
            end
        end
        m_prev = s;
        pipe.push_front(int'({a_in, b_in}));
        void'(pipe.pop_back());
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        obs_cyc++;
        if (step) begin
            obs_steps++;
            if (obs_first < 0) obs_first = obs_cyc;
        end
        if (wrap) obs_wraps++;
    endtask

    task automatic clear_obs();
        obs_steps = 0; obs_wraps = 0; obs_first = -1; obs_cyc = 0;
    endtask

    task automatic move(int delta, int hold);
        cur = (cur + delta + 4) % 4;
        {a_in, b_in} = 2'(gray[cur]);
        repeat (hold) cycle();
    endtask

    task automatic do_reset(int pins);
        reset = 1'b0;
        {a_in, b_in} = 2'(pins);
        repeat (3) cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        do_reset($urandom_range(0, 3));
        reset = 1'b0;
        cycle();
        checks++; if (step !== 1'b0) begin errors++; $display("[TB] FAIL reset_step got %b want 0", step); end
        checks++; if (dir !== 1'b1) begin errors++; $display("[TB] FAIL reset_dir got %b want 1", dir); end
        checks++; if (position !== '0) begin errors++; $display("[TB] FAIL reset_pos got %0d want 0", position); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrap got %b want 0", wrap); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err); end
        reset = 1'b1;
    endtask

    task automatic test_idle_high();
        {a_in, b_in} = 2'b11;
        clear_obs();
        repeat (10) cycle();
        checks++; if (obs_steps != 0) begin errors++; $display("[TB] FAIL idle_steps got %0d want 0", obs_steps); end
        checks++; if (position !== '0) begin errors++; $display("[TB] FAIL idle_pos got %0d want 0", position); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL idle_err got %b want 0", err); end
    endtask

    task automatic test_forward();
        do_reset(0);
        cur = 0;
        repeat (6) cycle();
        for (int i = 0; i < 4; i++) begin
            clear_obs();
            move(1, 4);
            checks++; if (obs_steps != 1) begin errors++; $display("[TB] FAIL fwd_steps[%0d] got %0d want 1", i, obs_steps); end
            checks++; if (position !== N'(i + 1)) begin errors++; $display("[TB] FAIL fwd_pos[%0d] got %0d want %0d", i, position, i + 1); end
            if (i == 0) begin
                checks++; if (obs_first != SYNC_STAGES + 1) begin errors++; $display("[TB] FAIL fwd_latency got %0d want %0d", obs_first, SYNC_STAGES + 1); end
            end
        end
        checks++; if (dir !== 1'b1) begin errors++; $display("[TB] FAIL fwd_dir got %b want 1", dir); end
        checks++; if (exp_vec() !== dut_vec()) begin errors++; $display("[TB] FAIL fwd_model got %h want %h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_wrap();
        repeat (11) move(1, 3);
        checks++; if (position !== N'(15)) begin errors++; $display("[TB] FAIL preload_pos got %0d want 15", position); end
        clear_obs();
        move(1, 4);
        checks++; if (position !== '0) begin errors++; $display("[TB] FAIL wrap_up_pos got %0d want 0", position); end
        checks++; if (obs_wraps != 1) begin errors++; $display("[TB] FAIL wrap_up_count got %0d want 1", obs_wraps); end
        clear_obs();
        move(-1, 4);
        checks++; if (position !== N'(15)) begin errors++; $display("[TB] FAIL wrap_dn_pos got %0d want 15", position); end
        checks++; if (obs_wraps != 1) begin errors++; $display("[TB] FAIL wrap_dn_count got %0d want 1", obs_wraps); end
        checks++; if (dir !== 1'b0) begin errors++; $display("[TB] FAIL wrap_dn_dir got %b want 0", dir); end
    endtask

    task automatic test_illegal();
        clear_obs();
        move(2, 4);
        checks++; if (obs_steps != 0) begin errors++; $display("[TB] FAIL illegal_steps got %0d want 0", obs_steps); end
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err got %b want 1", err); end
        checks++; if (position !== N'(15)) begin errors++; $display("[TB] FAIL illegal_pos got %0d want 15", position); end
        checks++; if (dir !== 1'b0) begin errors++; $display("[TB] FAIL illegal_dir got %b want 0", dir); end
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL clr_err got %b want 0", err); end
        move(2, SYNC_STAGES);
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL set_wins got %b want 1", err); end
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        cycle();
    endtask

    task automatic test_disable();
        enable = 1'b0;
        clear_obs();
        repeat (6) move(1, 3);
        enable = 1'b1;
        repeat (4) cycle();
        checks++; if (obs_steps != 0) begin errors++; $display("[TB] FAIL disabled_steps got %0d want 0", obs_steps); end
        checks++; if (position !== N'(15)) begin errors++; $display("[TB] FAIL disabled_pos got %0d want 15", position); end
        clear_obs();
        move(1, 4);
        checks++; if (obs_steps != 1) begin errors++; $display("[TB] FAIL reenable_steps got %0d want 1", obs_steps); end
        checks++; if (position !== '0) begin errors++; $display("[TB] FAIL reenable_pos got %0d want 0", position); end
    endtask

    task automatic test_reset_mid();
        do_reset(0);
        cur = 0;
        repeat (6) cycle();
        repeat (7) move(1, 3);
        checks++; if (position !== N'(7)) begin errors++; $display("[TB] FAIL mid_pre_pos got %0d want 7", position); end
        do_reset(2);
        cur = 3;
        checks++; if ({step, err, position} !== '0) begin errors++; $display("[TB] FAIL mid_reset got step=%b err=%b pos=%0d want all 0", step, err, position); end
        clear_obs();
        repeat (6) cycle();
        move(1, 4);
        checks++; if (obs_steps != 1) begin errors++; $display("[TB] FAIL mid_steps got %0d want 1", obs_steps); end
        checks++; if (position !== N'(1) || dir !== 1'b1) begin errors++; $display("[TB] FAIL mid_pos got pos=%0d dir=%b want pos=1 dir=1", position, dir); end
    endtask

    task automatic test_random();
        int r, delta;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            delta = (r < 4) ? 1 : (r < 8) ? 3 : (r == 8) ? 0 : 2;
            enable  = ($urandom_range(0, 7) != 0);
            clr_err = ($urandom_range(0, 5) == 0);
            cur = (cur + delta) % 4;
            {a_in, b_in} = 2'(gray[cur]);
            repeat ($urandom_range(1, 4)) begin
                cycle();
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++;
                    $display("[TB] FAIL random[%0d] {step,dir,wrap,err,pos} got %h want %h", i, dut_vec(), exp_vec());
                end
            end
        end
        enable  = 1'b1;
        clr_err = 1'b0;
    endtask

    initial begin
        clear_obs();
        test_reset();
        test_idle_high();
        test_forward();
        test_wrap();
        test_illegal();
        test_disable();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
